// File: rtl/cla_pkg.sv
// Shared types and constants for the cla_family multi-word adder controller.
// The optional subtract mode is enabled with CLA_CTRL_SUBTRACT_EN.
package cla_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cla_state_t;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_SLICE = 16;

   // Ceiling log2, used to size the slice index counter.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/cla_slice_adder.sv
// Combinational SLICE-bit carry-lookahead adder: 4-bit lookahead groups whose
// group generate/propagate terms feed a second lookahead level.
module cla_slice_adder #(
   parameter int SLICE = 16
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             ci,
   output logic [SLICE-1:0] s,
   output logic             co
);

   localparam int NG = SLICE / 4;

   logic [SLICE-1:0] g;
   logic [SLICE-1:0] p;
   logic [SLICE-1:0] c;
   logic [NG-1:0]    gg;
   logic [NG-1:0]    gp;
   logic [NG:0]      gc;

   assign g = a & b;
   assign p = a ^ b;

   // Group terms first, then group carries, then the bit carries inside each group.
   always_comb begin
      gg = '0;
      gp = '0;
      gc = '0;
      c  = '0;
      for (int k = 0; k < NG; k++) begin
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      end
      gc[0] = ci;
      for (int k = 0; k < NG; k++) begin
         gc[k+1] = gg[k] | (gp[k] & gc[k]);
      end
      for (int k = 0; k < NG; k++) begin
         c[4*k]   = gc[k];
         c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
         c[4*k+2] = g[4*k+1]
                  | (p[4*k+1] & g[4*k])
                  | (p[4*k+1] & p[4*k] & gc[k]);
         c[4*k+3] = g[4*k+2]
                  | (p[4*k+2] & g[4*k+1])
                  | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      end
   end

   assign s  = p ^ c;
   assign co = gc[NG];

endmodule

// File: rtl/cla_multiword_add_ctrl.sv
// Adds WIDTH-bit operands by stepping one SLICE-bit CLA over WIDTH/SLICE cycles.
// Defining CLA_CTRL_SUBTRACT_EN adds a 'sub' input selecting a-b.
module cla_multiword_add_ctrl
   import cla_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef CLA_CTRL_SUBTRACT_EN
   input  logic             sub,
`endif
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDXW   = (clog2(NSLICE) > 1) ? clog2(NSLICE) : 1;

   cla_state_t       state_q;
   cla_state_t       state_d;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             carry_r;
   logic [IDXW-1:0]  idx;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic [SLICE-1:0] slice_a;
   logic [SLICE-1:0] slice_b;
   logic [SLICE-1:0] slice_s;
   logic             slice_co;
   logic             last_slice;
   logic             accept;

   // Subtraction is a + ~b + 1, so the stored operand is already inverted.
`ifdef CLA_CTRL_SUBTRACT_EN
   assign b_eff   = sub ? ~b : b;
   assign cin_eff = sub ? 1'b1 : cin;
`else
   assign b_eff   = b;
   assign cin_eff = cin;
`endif

   assign slice_a    = a_r[int'(idx)*SLICE +: SLICE];
   assign slice_b    = b_r[int'(idx)*SLICE +: SLICE];
   assign last_slice = (idx == IDXW'(NSLICE - 1));
   assign accept     = in_valid && in_ready;

   cla_slice_adder #(
      .SLICE (SLICE)
   ) u_slice (
      .a  (slice_a),
      .b  (slice_b),
      .ci (carry_r),
      .s  (slice_s),
      .co (slice_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      res_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (last_slice) begin
               state_d = DONE;
            end
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand capture, per-slice accumulation and final flag capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r     <= '0;
         b_r     <= '0;
         carry_r <= 1'b0;
         idx     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else if (accept) begin
         a_r     <= a;
         b_r     <= b_eff;
         carry_r <= cin_eff;
         idx     <= '0;
      end else if (state_q == RUN) begin
         sum[int'(idx)*SLICE +: SLICE] <= slice_s;
         carry_r <= slice_co;
         if (last_slice) begin
            idx  <= '0;
            cout <= slice_co;
            ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (slice_s[SLICE-1] != a_r[WIDTH-1]);
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cla_multiword_add_ctrl.sv
// Randomised self-checking bench for cla_multiword_add_ctrl against a plain
// arithmetic reference (honours CLA_CTRL_SUBTRACT_EN when defined).
module tb_cla_multiword_add_ctrl;

   localparam int WIDTH  = 64;
   localparam int SLICE  = 16;
   localparam int NSLICE = WIDTH / SLICE;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef CLA_CTRL_SUBTRACT_EN
   logic             sub;
`endif
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int vecCount  = 0;
   int missCount = 0;

   cla_multiword_add_ctrl #(
      .WIDTH (WIDTH),
      .SLICE (SLICE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef CLA_CTRL_SUBTRACT_EN
      .sub       (sub),
`endif
      .res_valid (res_valid),
      .res_ready (res_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                              input logic [WIDTH-1:0] expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Reference: wide addition of a and the effective b, flags from operand signs.
   function automatic logic [WIDTH+1:0] refAdd(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                               input logic rcin, input logic rsub);
      logic [WIDTH-1:0] bEff;
      logic             c0;
      logic [WIDTH:0]   full;
      logic             v;
      bEff = rsub ? ~rb : rb;
      c0   = rsub ? 1'b1 : rcin;
      full = {1'b0, ra} + {1'b0, bEff} + {{WIDTH{1'b0}}, c0};
      v    = (ra[WIDTH-1] == bEff[WIDTH-1]) && (full[WIDTH-1] != ra[WIDTH-1]);
      return {v, full};
   endfunction

   function automatic logic [WIDTH-1:0] carryPattern();
      logic [WIDTH-1:0] w;
      for (int k = 0; k < NSLICE; k++) begin
         case ($urandom_range(0, 2))
            0:       w[k*SLICE +: SLICE] = '1;
            1:       w[k*SLICE +: SLICE] = '0;
            default: w[k*SLICE +: SLICE] = SLICE'($urandom);
         endcase
      end
      return w;
   endfunction

   // Full transaction: accept, time the result, check it, hold it, release it.
   task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                input logic tcin, input logic tsub, input int holdLow);
      logic [WIDTH+1:0] expv;
      logic             busyReady;
      int               n;
      int               lat;
      expv = refAdd(ta, tb, tcin, tsub);
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("accept_ready", WIDTH'(in_ready), 1);
      a        = ta;
      b        = tb;
      cin      = tcin;
`ifdef CLA_CTRL_SUBTRACT_EN
      sub      = tsub;
`endif
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a        = {$urandom, $urandom};
      b        = {$urandom, $urandom};
      cin      = 1'($urandom);
      busyReady = 1'b0;
      lat = 0;
      while (!res_valid && lat < 3 * NSLICE) begin
         busyReady = busyReady | in_ready;
         @(negedge clk);
         lat++;
      end
      checkOutput("latency", WIDTH'(lat), NSLICE);
      checkOutput("in_ready_busy", WIDTH'(busyReady), 0);
      checkOutput("sum", sum, expv[WIDTH-1:0]);
      checkOutput("cout", WIDTH'(cout), WIDTH'(expv[WIDTH]));
      checkOutput("ovf", WIDTH'(ovf), WIDTH'(expv[WIDTH+1]));
      for (int h = 0; h < holdLow; h++) begin
         in_valid = 1'b1;
         a        = {$urandom, $urandom};
         @(negedge clk);
         checkOutput("hold_valid", WIDTH'(res_valid), 1);
         checkOutput("hold_sum", sum, expv[WIDTH-1:0]);
         checkOutput("hold_in_ready", WIDTH'(in_ready), 0);
      end
      in_valid  = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checkOutput("release_valid", WIDTH'(res_valid), 0);
      checkOutput("release_idle", WIDTH'(in_ready), 1);
   endtask

   initial begin
      logic tsub;
      rst       = 1'b1;
      in_valid  = 1'b0;
      res_ready = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
`ifdef CLA_CTRL_SUBTRACT_EN
      sub       = 1'b0;
`endif
      repeat (2) @(negedge clk);
      checkOutput("reset_in_ready", WIDTH'(in_ready), 1);
      checkOutput("reset_res_valid", WIDTH'(res_valid), 0);
      checkOutput("reset_sum", sum, 0);
      checkOutput("reset_flags", WIDTH'({cout, ovf}), 0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] directed cases");
      applyStimulus(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 0);
      applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 1);
      applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
      applyStimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 5);

      $display("[TB] reset during RUN");
      a        = 64'h1234_5678_9ABC_DEF0;
      b        = 64'h0FED_CBA9_8765_4321;
      cin      = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midrun_res_valid", WIDTH'(res_valid), 0);
      checkOutput("midrun_in_ready", WIDTH'(in_ready), 1);
      checkOutput("midrun_sum", sum, 0);
      checkOutput("midrun_flags", WIDTH'({cout, ovf}), 0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(64'd3, 64'd4, 1'b0, 1'b0, 0);

`ifdef CLA_CTRL_SUBTRACT_EN
      applyStimulus(64'd5, 64'd7, 1'b0, 1'b1, 0);
`else
      applyStimulus(64'd5, 64'd7, 1'b0, 1'b0, 0);
`endif

      $display("[TB] randomised cases");
      for (int i = 0; i < 40; i++) begin
`ifdef CLA_CTRL_SUBTRACT_EN
         tsub = 1'($urandom);
`else
         tsub = 1'b0;
`endif
         if (i % 2 == 0) begin
            applyStimulus(carryPattern(), carryPattern(), 1'($urandom), tsub, $urandom_range(0, 3));
         end else begin
            applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), tsub,
                          $urandom_range(0, 3));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
